conv_sequencer: RTL and testbench

Control FSM for the convolution datapath, driven by the start, done and configuration fields of the wishbone config block. On a start request it walks every output position and every kernel. For each pair it issues the K×K tap read addresses to the feature-map and kernel memories, then steers the MAC enable/clear and the result write handshake. It raises done for the config block's status bit when the whole pass is finished.

---
 rtl/conv_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_conv_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sequencer.sv
// conv_sequencer: control FSM for the convolution datapath.
// For every output position and kernel it issues K*K tap reads, steers the MAC and writes the result.
module conv_sequencer #(
  parameter int FA_W    = 16,
  parameter int KA_W    = 10,
  parameter int RA_W    = 12,
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 2
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            start,
  output logic            done,
  input  logic [2:0]      kern_cols,
  input  logic [7:0]      cols,
  input  logic [2:0]      kerns,
  input  logic [7:0]      stride,
  input  logic            kern_addr_mode,
  input  logic [7:0]      result_cols,
  output logic            busy,
  output logic [FA_W-1:0] fm_addr,
  output logic [KA_W-1:0] kern_addr,
  output logic            rd_en,
  output logic            mac_en,
  output logic            mac_clr,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [RA_W-1:0] res_addr
);

  localparam logic [3:0] DRAIN_LAST = 4'(RD_LAT + MAC_LAT - 1);

  typedef enum logic [2:0] {IDLE, TAP, DRAIN, WRITE, DONE} state_t;

  state_t state_q, state_d;
  logic start_q;

  logic [7:0] cols_q, cols_d, stride_q, stride_d, resCols_q, resCols_d;
  logic [2:0] kk_q, kk_d, kerns_q, kerns_d;
  logic       mode_q, mode_d;

  logic [2:0]      r_q, r_d, c_q, c_d, k_q, k_d;
  logic [5:0]      rowK_q, rowK_d, colK_q, colK_d;
  logic [7:0]      j_q, j_d;
  logic [3:0]      drain_q, drain_d;
  logic [FA_W-1:0] rowCols_q, rowCols_d, jBase_q, jBase_d;
  logic [KA_W-1:0] kernBase_q, kernBase_d;
  logic [RA_W-1:0] resAddr_q, resAddr_d;

  logic [FA_W-1:0] fmAddr_q, fmAddr_d;
  logic [KA_W-1:0] kernAddr_q, kernAddr_d;
  logic [RA_W-1:0] resOut_q, resOut_d;
  logic            rdEn_q, rdEn_d, first_q, first_d;
  logic            resValid_q, resValid_d, busy_q, busy_d, done_q, done_d;
  logic [RD_LAT-1:0] enPipe_q, clrPipe_q;

  logic       accept;
  logic [5:0] tapOff;

  // Next-state and running-adder address generation; addresses are derived from the _d counters
  // so that the registered outputs line up with the state they belong to.
  always_comb begin
    state_d    = state_q;
    cols_d     = cols_q;
    stride_d   = stride_q;
    resCols_d  = resCols_q;
    kk_d       = kk_q;
    kerns_d    = kerns_q;
    mode_d     = mode_q;
    r_d        = r_q;
    c_d        = c_q;
    k_d        = k_q;
    j_d        = j_q;
    rowK_d     = rowK_q;
    colK_d     = colK_q;
    drain_d    = drain_q;
    rowCols_d  = rowCols_q;
    jBase_d    = jBase_q;
    kernBase_d = kernBase_q;
    resAddr_d  = resAddr_q;
    done_d     = done_q;

    accept = start && !start_q && (state_q == IDLE);

    case (state_q)
      IDLE: begin
        if (accept) begin
          cols_d     = cols;
          stride_d   = stride;
          resCols_d  = result_cols;
          kk_d       = kern_cols;
          kerns_d    = kerns;
          mode_d     = kern_addr_mode;
          r_d        = '0;
          c_d        = '0;
          k_d        = '0;
          j_d        = '0;
          rowK_d     = '0;
          colK_d     = '0;
          rowCols_d  = '0;
          jBase_d    = '0;
          kernBase_d = '0;
          resAddr_d  = '0;
          done_d     = 1'b0;
          if (kern_cols != 3'd0 && kerns != 3'd0 && result_cols != 8'd0) state_d = TAP;
          else state_d = DONE;
        end
      end
      TAP: begin
        if (c_q == kk_q - 3'd1) begin
          c_d    = '0;
          colK_d = '0;
          if (r_q == kk_q - 3'd1) begin
            // rowK+c+1 at the last tap equals K*K, the stride between kernel bases
            kernBase_d = kernBase_q + KA_W'(rowK_q) + KA_W'(c_q) + KA_W'(1);
            r_d        = '0;
            rowK_d     = '0;
            rowCols_d  = '0;
            drain_d    = '0;
            state_d    = DRAIN;
          end else begin
            r_d       = r_q + 3'd1;
            rowK_d    = rowK_q + 6'(kk_q);
            rowCols_d = rowCols_q + FA_W'(cols_q);
          end
        end else begin
          c_d    = c_q + 3'd1;
          colK_d = colK_q + 6'(kk_q);
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = WRITE;
        else drain_d = drain_q + 4'd1;
      end
      WRITE: begin
        if (res_ready) begin
          if (k_q == kerns_q - 3'd1) begin
            k_d        = '0;
            kernBase_d = '0;
            j_d        = j_q + 8'd1;
            jBase_d    = jBase_q + FA_W'(stride_q);
            resAddr_d  = RA_W'(j_q) + RA_W'(1);
            if (j_q == resCols_q - 8'd1) state_d = DONE;
            else state_d = TAP;
          end else begin
            k_d       = k_q + 3'd1;
            resAddr_d = resAddr_q + RA_W'(resCols_q);
            state_d   = TAP;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    tapOff     = mode_d ? (colK_d + 6'(r_d)) : (rowK_d + 6'(c_d));
    rdEn_d     = (state_d == TAP);
    first_d    = (state_d == TAP) && (r_d == 3'd0) && (c_d == 3'd0);
    fmAddr_d   = (state_d == TAP) ? (jBase_d + rowCols_d + FA_W'(c_d)) : '0;
    kernAddr_d = (state_d == TAP) ? (kernBase_d + KA_W'(tapOff)) : '0;
    resValid_d = (state_d == WRITE);
    resOut_d   = (state_d == WRITE) ? resAddr_d : '0;
    busy_d     = (state_d == TAP) || (state_d == DRAIN) || (state_d == WRITE);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      cols_q     <= '0;
      stride_q   <= '0;
      resCols_q  <= '0;
      kk_q       <= '0;
      kerns_q    <= '0;
      mode_q     <= 1'b0;
      r_q        <= '0;
      c_q        <= '0;
      k_q        <= '0;
      j_q        <= '0;
      rowK_q     <= '0;
      colK_q     <= '0;
      drain_q    <= '0;
      rowCols_q  <= '0;
      jBase_q    <= '0;
      kernBase_q <= '0;
      resAddr_q  <= '0;
      fmAddr_q   <= '0;
      kernAddr_q <= '0;
      resOut_q   <= '0;
      rdEn_q     <= 1'b0;
      first_q    <= 1'b0;
      resValid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      enPipe_q   <= '0;
      clrPipe_q  <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start;
      cols_q     <= cols_d;
      stride_q   <= stride_d;
      resCols_q  <= resCols_d;
      kk_q       <= kk_d;
      kerns_q    <= kerns_d;
      mode_q     <= mode_d;
      r_q        <= r_d;
      c_q        <= c_d;
      k_q        <= k_d;
      j_q        <= j_d;
      rowK_q     <= rowK_d;
      colK_q     <= colK_d;
      drain_q    <= drain_d;
      rowCols_q  <= rowCols_d;
      jBase_q    <= jBase_d;
      kernBase_q <= kernBase_d;
      resAddr_q  <= resAddr_d;
      fmAddr_q   <= fmAddr_d;
      kernAddr_q <= kernAddr_d;
      resOut_q   <= resOut_d;
      rdEn_q     <= rdEn_d;
      first_q    <= first_d;
      resValid_q <= resValid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      enPipe_q   <= RD_LAT'({enPipe_q, rdEn_q});
      clrPipe_q  <= RD_LAT'({clrPipe_q, first_q});
    end
  end

  assign done      = done_q;
  assign busy      = busy_q;
  assign fm_addr   = fmAddr_q;
  assign kern_addr = kernAddr_q;
  assign rd_en     = rdEn_q;
  assign mac_en    = enPipe_q[RD_LAT-1];
  assign mac_clr   = clrPipe_q[RD_LAT-1];
  assign res_valid = resValid_q;
  assign res_addr  = resOut_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: table-driven passes with a tap/write/MAC scoreboard plus hand-written
// sequences for backpressure, start-edge handling and asynchronous reset mid-pass.
module tb_conv_sequencer;
  localparam int RD_LAT  = 1;
  localparam int MAC_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        done;
  logic [2:0]  kern_cols;
  logic [7:0]  cols;
  logic [2:0]  kerns;
  logic [7:0]  stride;
  logic        kern_addr_mode;
  logic [7:0]  result_cols;
  logic        busy;
  logic [15:0] fm_addr;
  logic [9:0]  kern_addr;
  logic        rd_en;
  logic        mac_en;
  logic        mac_clr;
  logic        res_valid;
  logic        res_ready;
  logic [11:0] res_addr;

  conv_sequencer #(.FA_W(16), .KA_W(10), .RA_W(12), .RD_LAT(RD_LAT), .MAC_LAT(MAC_LAT)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .done(done),
    .kern_cols(kern_cols), .cols(cols), .kerns(kerns), .stride(stride),
    .kern_addr_mode(kern_addr_mode), .result_cols(result_cols), .busy(busy),
    .fm_addr(fm_addr), .kern_addr(kern_addr), .rd_en(rd_en), .mac_en(mac_en),
    .mac_clr(mac_clr), .res_valid(res_valid), .res_ready(res_ready), .res_addr(res_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int k; int cols; int kerns; int stride; int mode; int rc; int cycles;
  } cfgVec_t;
  typedef struct { int fm; int kern; bit clr; } tap_t;
  typedef struct { int due; bit clr; } mac_t;

  int   total = 0;
  int   bad   = 0;
  int   cycle = 0;
  tap_t tapQ[$];
  int   wrQ[$];
  mac_t macQ[$];
  cfgVec_t vecs[7];

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor, sampled 1 ns before each rising edge
  always @(negedge clk) begin : monitor
    tap_t t;
    mac_t m;
    int   w;
    #4;
    cycle++;
    if (!rst) begin
      if (rd_en) begin
        if (tapQ.size() == 0) checkOutput("unexpectedRead", 1, 0);
        else begin
          t = tapQ.pop_front();
          checkOutput("fm_addr", int'(fm_addr), t.fm);
          checkOutput("kern_addr", int'(kern_addr), t.kern);
          m.due = cycle + RD_LAT;
          m.clr = t.clr;
          macQ.push_back(m);
        end
      end else begin
        checkOutput("fmIdleZero", int'(fm_addr), 0);
        checkOutput("kernIdleZero", int'(kern_addr), 0);
      end
      if (macQ.size() > 0 && macQ[0].due == cycle) begin
        m = macQ.pop_front();
        checkOutput("mac_en", int'(mac_en), 1);
        checkOutput("mac_clr", int'(mac_clr), int'(m.clr));
      end else if (mac_en || mac_clr) begin
        checkOutput("unexpectedMac", 1, 0);
      end
      if (res_valid && res_ready) begin
        if (wrQ.size() == 0) checkOutput("unexpectedWrite", 1, 0);
        else begin
          w = wrQ.pop_front();
          checkOutput("res_addr", int'(res_addr), w);
        end
      end
      if (!res_valid) checkOutput("resIdleZero", int'(res_addr), 0);
    end
  end

  task automatic pushExpect(input cfgVec_t v);
    tap_t t;
    if (v.k == 0 || v.kerns == 0 || v.rc == 0) return;
    for (int j = 0; j < v.rc; j++)
      for (int kk = 0; kk < v.kerns; kk++) begin
        for (int r = 0; r < v.k; r++)
          for (int c = 0; c < v.k; c++) begin
            t.fm   = (j * v.stride + r * v.cols + c) & 32'hFFFF;
            t.kern = kk * v.k * v.k + (v.mode != 0 ? c * v.k + r : r * v.k + c);
            t.clr  = (r == 0 && c == 0);
            tapQ.push_back(t);
          end
        wrQ.push_back(kk * v.rc + j);
      end
  endtask

  task automatic applyStimulus(input cfgVec_t v, input int toggleAt);
    int n;
    kern_cols      = 3'(v.k);
    cols           = 8'(v.cols);
    kerns          = 3'(v.kerns);
    stride         = 8'(v.stride);
    kern_addr_mode = v.mode[0];
    result_cols    = 8'(v.rc);
    pushExpect(v);
    start = 1'b1;
    @(negedge clk);
    checkOutput("doneClears", int'(done), 0);
    if (v.k == 0 || v.kerns == 0 || v.rc == 0) begin
      checkOutput("busyDegenerate", int'(busy), 0);
      @(negedge clk);
      checkOutput("doneDegenerate", int'(done), 1);
      checkOutput("busyDegenerate2", int'(busy), 0);
    end else begin
      checkOutput("busyRise", int'(busy), 1);
      n = 0;
      while (!done && n < 5000) begin
        @(negedge clk);
        n++;
        if (toggleAt > 0 && n == toggleAt) start = 1'b0;
        if (toggleAt > 0 && n == toggleAt + 1) start = 1'b1;
      end
      checkOutput("passCycles", n, v.cycles);
      checkOutput("busyAtDone", int'(busy), 0);
    end
    checkOutput("tapQueueEmpty", tapQ.size(), 0);
    checkOutput("writeQueueEmpty", wrQ.size(), 0);
  endtask

  task automatic idleCheck(input int n);
    repeat (n) @(negedge clk);
    checkOutput("idleBusy", int'(busy), 0);
    checkOutput("idleDone", int'(done), 1);
  endtask

  initial begin
    int n;
    //            K  cols kerns stride mode rc cycles
    vecs[0] = '{3,   8,   1,    1,    0,  2,   27};
    vecs[1] = '{2,   8,   3,    2,    1,  1,   25};
    vecs[2] = '{1,   5,   2,    3,    0,  3,   31};
    vecs[3] = '{7, 255,   1,  255,    1,  2,  107};
    vecs[4] = '{0,   8,   1,    1,    0,  2,    0};
    vecs[5] = '{3,   8,   0,    1,    0,  2,    0};
    vecs[6] = '{3,   8,   1,    1,    0,  0,    0};

    rst = 1'b1; start = 1'b0; res_ready = 1'b1;
    kern_cols = '0; cols = '0; kerns = '0; stride = '0; kern_addr_mode = 1'b0; result_cols = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", int'(busy), 0);
    checkOutput("rstDone", int'(done), 0);
    checkOutput("rstRdEn", int'(rd_en), 0);
    checkOutput("rstResValid", int'(res_valid), 0);
    checkOutput("rstFmAddr", int'(fm_addr), 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postRstBusy", int'(busy), 0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], 0);
      // start is still high: no edge, so no second pass
      if (i == 0) idleCheck(20);
      start = 1'b0;
      @(negedge clk);
    end

    $display("[TB] start toggle during busy");
    applyStimulus(vecs[1], 5);
    idleCheck(15);
    start = 1'b0;
    @(negedge clk);

    $display("[TB] backpressure on first write");
    res_ready = 1'b0;
    kern_cols = 3'd3; cols = 8'd8; kerns = 3'd1; stride = 8'd1; kern_addr_mode = 1'b0; result_cols = 8'd2;
    pushExpect(vecs[0]);
    start = 1'b1;
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stallValidSeen", int'(res_valid), 1);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checkOutput("stallValid", int'(res_valid), 1);
      checkOutput("stallAddr", int'(res_addr), 0);
      checkOutput("stallNoRead", int'(rd_en), 0);
    end
    res_ready = 1'b1;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stallDone", int'(done), 1);
    checkOutput("stallTapQ", tapQ.size(), 0);
    checkOutput("stallWrQ", wrQ.size(), 0);
    start = 1'b0;
    @(negedge clk);

    $display("[TB] asynchronous reset during taps");
    pushExpect(vecs[0]);
    start = 1'b1;
    n = 0;
    while (!rd_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midTapReached", int'(rd_en), 1);
    repeat (3) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("arstRdEn", int'(rd_en), 0);
    checkOutput("arstFm", int'(fm_addr), 0);
    checkOutput("arstKern", int'(kern_addr), 0);
    checkOutput("arstMacEn", int'(mac_en), 0);
    checkOutput("arstMacClr", int'(mac_clr), 0);
    checkOutput("arstResValid", int'(res_valid), 0);
    checkOutput("arstResAddr", int'(res_addr), 0);
    checkOutput("arstBusy", int'(busy), 0);
    checkOutput("arstDone", int'(done), 0);
    tapQ.delete();
    wrQ.delete();
    macQ.delete();
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(vecs[0], 0);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("finalMacQ", macQ.size(), 0);

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
